// File: rtl/neat_gene_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : neat_gene_pkg
//  Brief    : Shared layer encodings, default gene field offsets and scanner
//             FSM state encodings for the NEAT genome datapath.
//  Revision : 1.0  initial release
// ============================================================================
package neat_gene_pkg;

   // Layer field values carried in each node gene
   localparam logic [1:0] LAYER_HID  = 2'b00;
   localparam logic [1:0] LAYER_IN   = 2'b01;
   localparam logic [1:0] LAYER_OUT  = 2'b10;
   localparam logic [1:0] LAYER_NONE = 2'b11;

   // Default bit positions of the node_id and layer fields in a gene word
   localparam int DEF_ID_LSB    = 40;
   localparam int DEF_LAYER_LSB = 53;

   // Scanner FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/layer_range_acc.sv
`default_nettype none
// ============================================================================
//  Module   : layer_range_acc
//  Brief    : Min / max / saturating-count accumulator for the node IDs of a
//             single layer. clr reloads the empty-layer values.
//  Revision : 1.0  initial release
// ============================================================================
module layer_range_acc #(
   parameter int ATTR_SZ = 8,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [ATTR_SZ-1:0] id,
   output logic [ATTR_SZ-1:0] min,
   output logic [ATTR_SZ-1:0] max,
   output logic [CNT_W-1:0]   cnt
);

   logic [ATTR_SZ-1:0] r_min;
   logic [ATTR_SZ-1:0] r_max;
   logic [CNT_W-1:0]   r_cnt;

   // Track unsigned min/max and a count that sticks at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_min <= '1;
         r_max <= '0;
         r_cnt <= '0;
      end else if (clr) begin
         r_min <= '1;
         r_max <= '0;
         r_cnt <= '0;
      end else if (en) begin
         if (id < r_min) r_min <= id;
         if (id > r_max) r_max <= id;
         if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign min = r_min;
   assign max = r_max;
   assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/node_range_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : node_range_scanner
//  Brief    : Scans one genome's gene stream, gathering per-layer node ID
//             min/max/count, and reports the next free hidden node ID.
//  Revision : 1.0  initial release
// ============================================================================
module node_range_scanner
   import neat_gene_pkg::*;
#(
   parameter int GENE_SZ   = 64,
   parameter int ATTR_SZ   = 8,
   parameter int ID_LSB    = DEF_ID_LSB,
   parameter int LAYER_LSB = DEF_LAYER_LSB,
   parameter int CNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               gene_valid,
   output logic               gene_ready,
   input  logic               gene_last,
   input  logic [GENE_SZ-1:0] gene_in,
   output logic               busy,
   output logic               done,
   output logic [ATTR_SZ-1:0] hid_min,
   output logic [ATTR_SZ-1:0] hid_max,
   output logic [CNT_W-1:0]   hid_cnt,
   output logic [ATTR_SZ-1:0] in_min,
   output logic [ATTR_SZ-1:0] in_max,
   output logic [CNT_W-1:0]   in_cnt,
   output logic [ATTR_SZ-1:0] out_min,
   output logic [ATTR_SZ-1:0] out_max,
   output logic [CNT_W-1:0]   out_cnt,
   output logic [ATTR_SZ-1:0] next_id,
   output logic               id_overflow
);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [ATTR_SZ-1:0] r_next_id;
   logic               r_id_overflow;

   logic               w_hs;
   logic               w_clr;
   logic               w_finish;
   logic [ATTR_SZ-1:0] w_id;
   logic [1:0]         w_layer;
   logic               w_is_node;
   logic [ATTR_SZ-1:0] w_max_a;
   logic [ATTR_SZ-1:0] w_max_b;
   logic [ATTR_SZ-1:0] w_max_all;
   logic               w_unused_bits;

   // Ready depends on state only, so there is no valid->ready path
   assign gene_ready = (r_state == ST_SCAN);
   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);
   assign w_hs       = gene_valid & gene_ready;
   assign w_clr      = (r_state == ST_IDLE) & start;
   assign w_finish   = w_hs & gene_last;

   assign w_id          = gene_in[ID_LSB +: ATTR_SZ];
   assign w_layer       = gene_in[LAYER_LSB +: 2];
   assign w_is_node     = (w_layer != LAYER_NONE);
   assign w_unused_bits = ^gene_in;

   // Next-state logic for the IDLE -> SCAN -> DONE -> IDLE sequence
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start)    w_state_nxt = ST_SCAN;
         ST_SCAN: if (w_finish) w_state_nxt = ST_DONE;
         ST_DONE:               w_state_nxt = ST_IDLE;
         default:               w_state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   layer_range_acc #(.ATTR_SZ(ATTR_SZ), .CNT_W(CNT_W)) u_acc_hid (
      .clk (clk), .rst (rst), .clr (w_clr),
      .en  (w_hs & (w_layer == LAYER_HID)), .id (w_id),
      .min (hid_min), .max (hid_max), .cnt (hid_cnt)
   );

   layer_range_acc #(.ATTR_SZ(ATTR_SZ), .CNT_W(CNT_W)) u_acc_in (
      .clk (clk), .rst (rst), .clr (w_clr),
      .en  (w_hs & (w_layer == LAYER_IN)), .id (w_id),
      .min (in_min), .max (in_max), .cnt (in_cnt)
   );

   layer_range_acc #(.ATTR_SZ(ATTR_SZ), .CNT_W(CNT_W)) u_acc_out (
      .clk (clk), .rst (rst), .clr (w_clr),
      .en  (w_hs & (w_layer == LAYER_OUT)), .id (w_id),
      .min (out_min), .max (out_max), .cnt (out_cnt)
   );

   // The final gene is still in flight when next_id is captured, so fold its
   // ID into the max directly instead of waiting for the accumulators
   always_comb begin
      w_max_a   = (hid_max > in_max) ? hid_max : in_max;
      w_max_b   = (out_max > w_max_a) ? out_max : w_max_a;
      w_max_all = (w_is_node && (w_id > w_max_b)) ? w_id : w_max_b;
   end

   // Capture next free ID on the SCAN -> DONE edge, clamping at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_next_id     <= '0;
         r_id_overflow <= 1'b0;
      end else if (w_finish) begin
         if (w_max_all == {ATTR_SZ{1'b1}}) begin
            r_next_id     <= '1;
            r_id_overflow <= 1'b1;
         end else begin
            r_next_id     <= w_max_all + 1'b1;
            r_id_overflow <= 1'b0;
         end
      end
   end

   assign next_id     = r_next_id;
   assign id_overflow = r_id_overflow;

endmodule
`default_nettype wire

// File: tb/tb_node_range_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_node_range_scanner
//  Brief    : Directed self-checking bench for node_range_scanner.
//  Revision : 1.0  initial release
// ============================================================================
module tb_node_range_scanner;

   localparam logic [1:0] L_HID  = 2'b00;
   localparam logic [1:0] L_IN   = 2'b01;
   localparam logic [1:0] L_OUT  = 2'b10;
   localparam logic [1:0] L_NONE = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        gene_valid;
   logic        gene_ready;
   logic        gene_last;
   logic [63:0] gene_in;
   logic        busy;
   logic        done;
   logic [7:0]  hid_min, hid_max, hid_cnt;
   logic [7:0]  in_min, in_max, in_cnt;
   logic [7:0]  out_min, out_max, out_cnt;
   logic [7:0]  next_id;
   logic        id_overflow;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   node_range_scanner dut (
      .clk (clk), .rst (rst), .start (start),
      .gene_valid (gene_valid), .gene_ready (gene_ready),
      .gene_last (gene_last), .gene_in (gene_in),
      .busy (busy), .done (done),
      .hid_min (hid_min), .hid_max (hid_max), .hid_cnt (hid_cnt),
      .in_min (in_min), .in_max (in_max), .in_cnt (in_cnt),
      .out_min (out_min), .out_max (out_max), .out_cnt (out_cnt),
      .next_id (next_id), .id_overflow (id_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Gene word with noise outside the ID and layer fields
   function automatic logic [63:0] mk(input logic [1:0] layer, input logic [7:0] id);
      logic [63:0] g;
      g = 64'hF0F0_F0F0_F0F0_F0F0;
      g[47:40] = id;
      g[54:53] = layer;
      return g;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [1:0] layer, input logic [7:0] id, input logic last);
      gene_valid = 1'b1;
      gene_in    = mk(layer, id);
      gene_last  = last;
      tick();
      gene_valid = 1'b0;
      gene_last  = 1'b0;
   endtask

   task automatic chk_mixed(input string p);
      chk({p, "_in_min"},  in_min,  1);
      chk({p, "_in_max"},  in_max,  2);
      chk({p, "_in_cnt"},  in_cnt,  2);
      chk({p, "_out_min"}, out_min, 3);
      chk({p, "_out_max"}, out_max, 3);
      chk({p, "_out_cnt"}, out_cnt, 1);
      chk({p, "_hid_min"}, hid_min, 5);
      chk({p, "_hid_max"}, hid_max, 7);
      chk({p, "_hid_cnt"}, hid_cnt, 2);
      chk({p, "_next_id"}, next_id, 8);
      chk({p, "_ovf"},     id_overflow, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; gene_valid = 1'b0; gene_last = 1'b0; gene_in = '0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_ready", gene_ready, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      chk("rst_ovf",   id_overflow, 0);
      chk("rst_hid_min", hid_min, 255);
      chk("rst_in_min",  in_min, 255);
      chk("rst_out_max", out_max, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_next_id", next_id, 0);

      // Valid without start is ignored
      gene_valid = 1'b1; gene_in = mk(L_IN, 8'd9);
      tick();
      chk("idle_ready", gene_ready, 0);
      chk("idle_busy",  busy, 0);
      chk("idle_in_cnt", in_cnt, 0);
      gene_valid = 1'b0;

      // Mixed genome back to back
      do_start();
      chk("scan_busy",  busy, 1);
      chk("scan_ready", gene_ready, 1);
      send(L_IN, 8'd1, 0);
      chk("first_in_cnt", in_cnt, 1);
      send(L_IN, 8'd2, 0);
      send(L_OUT, 8'd3, 0);
      send(L_HID, 8'd7, 0);
      send(L_HID, 8'd5, 0);
      chk("pre_last_done", done, 0);
      send(L_NONE, 8'd200, 1);
      chk("mix_done", done, 1);
      chk("mix_busy", busy, 1);
      chk("mix_ready", gene_ready, 0);
      chk_mixed("mix");
      tick();
      chk("mix_done_pulse", done, 0);
      chk("mix_idle_busy", busy, 0);
      chk("mix_hold_hid_max", hid_max, 7);

      // Same genome with gaps
      do_start();
      chk("bp_clr_hid_cnt", hid_cnt, 0);
      tick(); send(L_IN, 8'd1, 0);
      tick(); send(L_IN, 8'd2, 0);
      tick(); send(L_OUT, 8'd3, 0);
      tick(); send(L_HID, 8'd7, 0);
      tick(); send(L_HID, 8'd5, 0);
      tick();
      chk("bp_gap_done", done, 0);
      send(L_NONE, 8'd200, 1);
      chk("bp_done", done, 1);
      chk_mixed("bp");

      // start during DONE is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_start_busy", busy, 0);
      chk("done_start_hold", in_cnt, 2);

      // Overflow
      do_start();
      send(L_HID, 8'd255, 1);
      chk("ovf_next_id", next_id, 255);
      chk("ovf_flag",    id_overflow, 1);
      chk("ovf_hid_max", hid_max, 255);
      chk("ovf_hid_cnt", hid_cnt, 1);
      tick();

      // Empty genome
      do_start();
      send(L_NONE, 8'd10, 1);
      chk("empty_done",    done, 1);
      chk("empty_hid_cnt", hid_cnt, 0);
      chk("empty_in_cnt",  in_cnt, 0);
      chk("empty_out_cnt", out_cnt, 0);
      chk("empty_in_min",  in_min, 255);
      chk("empty_out_max", out_max, 0);
      chk("empty_next_id", next_id, 1);
      chk("empty_ovf",     id_overflow, 0);
      tick();

      // Abort with reset mid-scan
      do_start();
      send(L_IN, 8'd4, 0);
      send(L_HID, 8'd20, 0);
      send(L_OUT, 8'd30, 0);
      rst = 1'b1;
      #1;
      chk("abort_busy",    busy, 0);
      chk("abort_hid_min", hid_min, 255);
      chk("abort_hid_cnt", hid_cnt, 0);
      chk("abort_out_max", out_max, 0);
      chk("abort_next_id", next_id, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("abort_done", done, 0);
      tick();
      chk("abort_done2", done, 0);

      // Fresh scan after abort
      do_start();
      send(L_IN, 8'd1, 0);
      send(L_IN, 8'd2, 0);
      send(L_OUT, 8'd3, 0);
      send(L_HID, 8'd7, 0);
      send(L_HID, 8'd5, 0);
      send(L_NONE, 8'd200, 1);
      chk("fresh_done", done, 1);
      chk_mixed("fresh");
      tick();

      // start during SCAN must not clear
      do_start();
      send(L_IN, 8'd1, 0);
      start = 1'b1;
      send(L_IN, 8'd2, 0);
      start = 1'b0;
      send(L_HID, 8'd9, 1);
      chk("mid_start_done",   done, 1);
      chk("mid_start_in_cnt", in_cnt, 2);
      chk("mid_start_in_min", in_min, 1);
      chk("mid_start_next",   next_id, 10);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
